// File: rtl/dr_channel_arbiter_pkg.sv
// rtl/dr_channel_arbiter_pkg.sv - shared types and dual-rail helpers for the channel arbiter
package dr_chan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        SPACER = 2'd2
    } state_t;

    localparam logic [7:0] DR_SPACER = 8'h00;

    // Bit i maps to rails {true, false} at positions {2i+1, 2i}.
    function automatic logic [7:0] dr_encode4(input logic [3:0] word);
        logic [7:0] code;
        code = '0;
        for (int i = 0; i < 4; i++) begin
            code[2*i+1] = word[i];
            code[2*i]   = ~word[i];
        end
        return code;
    endfunction

    function automatic logic dr_valid8(input logic [7:0] code);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (code[2*i+1] == code[2*i]) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/dr_channel_arbiter_if.sv
// rtl/dr_channel_arbiter_if.sv - requester and dual-rail channel signal bundle
interface dr_channel_arbiter_if;
    logic       req0;
    logic [3:0] data0;
    logic       done0;
    logic       req1;
    logic [3:0] data1;
    logic       done1;
    logic [7:0] dr_data;
    logic       dr_ack;

    modport slave (
        input  req0, data0, req1, data1, dr_ack,
        output done0, done1, dr_data
    );

    modport master (
        output req0, data0, req1, data1, dr_ack,
        input  done0, done1, dr_data
    );
endinterface

// File: rtl/dr_channel_arbiter_ack_sync.sv
// rtl/dr_channel_arbiter_ack_sync.sv - flop-chain synchroniser for the async acknowledge
module ack_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_sync
);
    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];
endmodule

// File: rtl/dr_channel_arbiter.sv
// rtl/dr_channel_arbiter.sv - round-robin share of one dual-rail RZ channel between two requesters
module dr_channel_arbiter
    import dr_chan_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 64,
    parameter int CNT_W       = 7
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    dr_channel_arbiter_if.slave  bus,
    input  logic                 i_err_clr,
    output logic                 o_busy,
    output logic                 o_grant_id,
    output logic                 o_timeout_err
);
    localparam logic [CNT_W-1:0] LP_TMO      = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LP_TMO_LAST = CNT_W'(TIMEOUT - 1);

    logic             w_ack_s;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_wdog;
    logic             w_wdog_last;
    logic [7:0]       r_dr_data;
    logic [7:0]       w_dr_data_nxt;
    logic             r_done0;
    logic             r_done1;
    logic             w_done0_nxt;
    logic             w_done1_nxt;
    logic             r_grant_id;
    logic             w_grant_nxt;
    logic             w_pick;
    logic             r_timeout_err;
    logic             w_to_set;
    logic             r_busy;

    ack_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (bus.dr_ack),
        .o_sync  (w_ack_s)
    );

    // The transition edge is the one on which the counter would reach TIMEOUT.
    assign w_wdog_last = (r_wdog >= LP_TMO_LAST);

    always_comb begin
        w_state_nxt   = r_state;
        w_dr_data_nxt = r_dr_data;
        w_grant_nxt   = r_grant_id;
        w_pick        = r_grant_id;
        w_done0_nxt   = 1'b0;
        w_done1_nxt   = 1'b0;
        w_to_set      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_ack_s && (bus.req0 || bus.req1)) begin
                    w_pick        = (bus.req0 && bus.req1) ? ~r_grant_id : bus.req1;
                    w_dr_data_nxt = dr_encode4(w_pick ? bus.data1 : bus.data0);
                    w_grant_nxt   = w_pick;
                    w_state_nxt   = DATA;
                end
            end
            DATA: begin
                if (w_ack_s) begin
                    w_dr_data_nxt = DR_SPACER;
                    w_state_nxt   = SPACER;
                end else if (w_wdog_last) begin
                    w_dr_data_nxt = DR_SPACER;
                    w_state_nxt   = SPACER;
                    w_to_set      = 1'b1;
                end
            end
            SPACER: begin
                if (!w_ack_s) begin
                    w_state_nxt = IDLE;
                    w_done0_nxt = ~r_grant_id;
                    w_done1_nxt = r_grant_id;
                end else if (w_wdog_last) begin
                    w_state_nxt = IDLE;
                    w_to_set    = 1'b1;
                end
            end
            default: begin
                w_dr_data_nxt = DR_SPACER;
                w_state_nxt   = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_wdog        <= '0;
            r_dr_data     <= DR_SPACER;
            r_done0       <= 1'b0;
            r_done1       <= 1'b0;
            r_grant_id    <= 1'b1;
            r_timeout_err <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_dr_data  <= w_dr_data_nxt;
            r_done0    <= w_done0_nxt;
            r_done1    <= w_done1_nxt;
            r_grant_id <= w_grant_nxt;
            r_busy     <= (w_state_nxt != IDLE);
            if (w_state_nxt != r_state) begin
                r_wdog <= '0;
            end else if (r_wdog != LP_TMO) begin
                r_wdog <= r_wdog + 1'b1;
            end
            if (w_to_set) begin
                r_timeout_err <= 1'b1;
            end else if (i_err_clr) begin
                r_timeout_err <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            assert (r_dr_data == DR_SPACER || dr_valid8(r_dr_data));
            assert (!(r_done0 && r_done1));
        end
    end

    assign bus.dr_data    = r_dr_data;
    assign bus.done0      = r_done0;
    assign bus.done1      = r_done1;
    assign o_busy         = r_busy;
    assign o_grant_id     = r_grant_id;
    assign o_timeout_err  = r_timeout_err;
endmodule

// File: tb/tb_dr_channel_arbiter.sv
// tb/tb_dr_channel_arbiter.sv - directed self-checking bench for dr_channel_arbiter
module tb_dr_channel_arbiter;
    import dr_chan_pkg::*;

    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err_clr = 1'b0;
    logic busy, grant_id, timeout_err;
    int   errors = 0;
    int   checks = 0;

    logic       ack_auto = 1'b1;
    logic       ack_manual = 1'b0;
    logic [2:0] ack_hist = 3'b000;

    dr_channel_arbiter_if bus();

    dr_channel_arbiter #(.SYNC_STAGES(2), .TIMEOUT(TMO), .CNT_W(7)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .bus           (bus),
        .i_err_clr     (err_clr),
        .o_busy        (busy),
        .o_grant_id    (grant_id),
        .o_timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Async stage model: ack follows "codeword present" three cycles late, or a manual level.
    always @(negedge clk) begin
        ack_hist   = {ack_hist[1:0], (bus.dr_data != 8'h00)};
        bus.dr_ack = ack_auto ? ack_hist[2] : ack_manual;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] decode(input logic [7:0] c);
        logic [3:0] d;
        for (int i = 0; i < 4; i++) d[i] = c[2*i+1];
        return d;
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (bus.dr_data !== 8'h00) begin errors++; $display("FAIL reset_dr_data: got %h want 00", bus.dr_data); end
        checks++; if ({bus.done0, bus.done1} !== 2'b00) begin errors++; $display("FAIL reset_done: got %b want 00", {bus.done0, bus.done1}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (grant_id !== 1'b1) begin errors++; $display("FAIL reset_grant_id: got %b want 1", grant_id); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single;
        int   n_d0 = 0, n_d1 = 0, bad = 0;
        logic seen_sp = 1'b0;
        bus.data0 = 4'hA;
        bus.req0  = 1'b1;
        tick();
        checks++; if (bus.dr_data !== 8'h99) begin errors++; $display("FAIL single_codeword: got %h want 99", bus.dr_data); end
        checks++; if (busy !== 1'b1 || grant_id !== 1'b0) begin errors++; $display("FAIL single_busy_gid: got %b%b want 10", busy, grant_id); end
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.dr_data !== 8'h99 && bus.dr_data !== 8'h00) bad++;
            if (bus.dr_data === 8'h00) seen_sp = 1'b1;
            if (bus.done0 === 1'b1) begin
                n_d0++;
                if (!seen_sp) bad++;
                bus.req0 = 1'b0;
            end
            if (bus.done1 === 1'b1) n_d1++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL single_sequence: got %0d bad cycles want 0", bad); end
        checks++; if (n_d0 != 1) begin errors++; $display("FAIL single_done0: got %0d pulses want 1", n_d0); end
        checks++; if (n_d1 != 0) begin errors++; $display("FAIL single_done1: got %0d pulses want 0", n_d1); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_contention;
        logic [7:0] exp_cw [4];
        logic       exp_id [4];
        logic [7:0] cw [4];
        logic       gid [4];
        logic [7:0] prev = 8'h00;
        int ng = 0, nd = 0, t_done = -10, gap_bad = 0, dseq_bad = 0;
        exp_cw = '{8'h5A, 8'hA5, 8'h5A, 8'hA5};
        exp_id = '{1'b0, 1'b1, 1'b0, 1'b1};
        cw     = '{8'h00, 8'h00, 8'h00, 8'h00};
        gid    = '{1'b1, 1'b1, 1'b1, 1'b1};
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        bus.data0 = 4'h3;
        bus.data1 = 4'hC;
        bus.req0  = 1'b1;
        bus.req1  = 1'b1;
        for (int t = 0; t < 200 && nd < 4; t++) begin
            tick();
            if (prev === 8'h00 && bus.dr_data !== 8'h00) begin
                if (ng < 4) begin
                    cw[ng]  = bus.dr_data;
                    gid[ng] = grant_id;
                end
                ng++;
                if (nd > 0 && (t - t_done) != 1) gap_bad++;
            end
            if (bus.done0 === 1'b1 || bus.done1 === 1'b1) begin
                if (bus.done1 !== nd[0]) dseq_bad++;
                nd++;
                t_done = t;
                if (nd == 4) begin
                    bus.req0 = 1'b0;
                    bus.req1 = 1'b0;
                end
            end
            prev = bus.dr_data;
        end
        checks++; if (nd != 4 || ng != 4) begin errors++; $display("FAIL contention_count: got %0d grants %0d dones want 4 4", ng, nd); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cw[i] !== exp_cw[i] || gid[i] !== exp_id[i]) begin
                errors++;
                $display("FAIL contention_grant%0d: got %h/%b want %h/%b", i, cw[i], gid[i], exp_cw[i], exp_id[i]);
            end
        end
        checks++; if (gap_bad != 0) begin errors++; $display("FAIL contention_back_to_back: got %0d late grants want 0", gap_bad); end
        checks++; if (dseq_bad != 0) begin errors++; $display("FAIL contention_done_order: got %0d misordered want 0", dseq_bad); end
        repeat (15) tick();
    endtask

    task automatic test_data_timeout;
        int held = 0;
        ack_auto   = 1'b0;
        ack_manual = 1'b0;
        bus.data0  = 4'h5;
        bus.req0   = 1'b1;
        tick();
        for (int k = 0; k < 30 && bus.dr_data === 8'h66; k++) begin
            held++;
            tick();
        end
        checks++; if (held != TMO) begin errors++; $display("FAIL data_to_hold: got %0d cycles want %0d", held, TMO); end
        checks++; if (bus.dr_data !== 8'h00 || timeout_err !== 1'b1) begin errors++; $display("FAIL data_to_spacer_err: got %h/%b want 00/1", bus.dr_data, timeout_err); end
        tick();
        checks++; if (bus.done0 !== 1'b1) begin errors++; $display("FAIL data_to_done: got %b want 1", bus.done0); end
        bus.req0 = 1'b0;
        tick();
        checks++; if (timeout_err !== 1'b1 || bus.done0 !== 1'b0) begin errors++; $display("FAIL data_to_sticky: got %b/%b want 1/0", timeout_err, bus.done0); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL data_to_clear: got %b want 0", timeout_err); end
    endtask

    task automatic test_spacer_timeout;
        int sp = 0, n_done = 0, n_busy = 0;
        logic got = 1'b0;
        ack_auto   = 1'b0;
        ack_manual = 1'b0;
        bus.data0  = 4'hF;
        bus.req0   = 1'b1;
        tick();
        checks++; if (bus.dr_data !== 8'hAA) begin errors++; $display("FAIL sp_to_codeword: got %h want aa", bus.dr_data); end
        ack_manual = 1'b1;
        for (int k = 0; k < 20 && bus.dr_data !== 8'h00; k++) tick();
        for (int k = 0; k < 30 && busy === 1'b1; k++) begin
            sp++;
            if (bus.done0 === 1'b1 || bus.done1 === 1'b1) n_done++;
            tick();
        end
        checks++; if (sp != TMO) begin errors++; $display("FAIL sp_to_hold: got %0d cycles want %0d", sp, TMO); end
        checks++; if (timeout_err !== 1'b1 || n_done != 0 || bus.done0 !== 1'b0) begin errors++; $display("FAIL sp_to_err_nodone: got %b/%0d want 1/0", timeout_err, n_done); end
        for (int k = 0; k < 10; k++) begin
            tick();
            if (busy === 1'b1 || bus.dr_data !== 8'h00) n_busy++;
        end
        checks++; if (n_busy != 0) begin errors++; $display("FAIL sp_to_blocked: got %0d grant cycles want 0", n_busy); end
        ack_manual = 1'b0;
        repeat (3) tick();
        checks++; if (bus.dr_data !== 8'hAA) begin errors++; $display("FAIL sp_to_regrant: got %h want aa", bus.dr_data); end
        ack_auto = 1'b1;
        for (int k = 0; k < 40 && !got; k++) begin
            tick();
            if (bus.done0 === 1'b1) got = 1'b1;
        end
        bus.req0 = 1'b0;
        checks++; if (!got) begin errors++; $display("FAIL sp_to_finish: got no done0 want done0"); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        repeat (5) tick();
    endtask

    task automatic test_reset_mid;
        logic got = 1'b0;
        logic seen = 1'b0;
        ack_auto  = 1'b1;
        bus.data0 = 4'h6;
        bus.req0  = 1'b1;
        repeat (2) tick();
        checks++; if (bus.dr_data !== 8'h69 || grant_id !== 1'b0) begin errors++; $display("FAIL rmid_pre: got %h/%b want 69/0", bus.dr_data, grant_id); end
        rst = 1'b1;
        tick();
        checks++; if (bus.dr_data !== 8'h00) begin errors++; $display("FAIL rmid_spacer: got %h want 00", bus.dr_data); end
        checks++; if ({bus.done0, bus.done1} !== 2'b00) begin errors++; $display("FAIL rmid_done: got %b want 00", {bus.done0, bus.done1}); end
        checks++; if (grant_id !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rmid_gid_busy: got %b/%b want 1/0", grant_id, busy); end
        rst = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            tick();
            if (bus.dr_data === 8'h69) seen = 1'b1;
            if (bus.done0 === 1'b1) got = 1'b1;
        end
        bus.req0 = 1'b0;
        checks++; if (!got || !seen) begin errors++; $display("FAIL rmid_resume: got done=%b cw=%b want 1/1", got, seen); end
        repeat (10) tick();
    endtask

    task automatic test_encoding_sweep;
        ack_auto = 1'b1;
        for (int v = 0; v < 16; v++) begin
            logic got = 1'b0;
            logic bad = 1'b0;
            logic [3:0] vv;
            vv = 4'(v);
            bus.data0 = vv;
            bus.req0  = 1'b1;
            for (int k = 0; k < 60 && !got; k++) begin
                tick();
                if (bus.dr_data !== 8'h00) begin
                    if (!dr_valid8(bus.dr_data) || decode(bus.dr_data) !== vv) bad = 1'b1;
                end
                if (bus.done0 === 1'b1) begin
                    got = 1'b1;
                    bus.req0 = 1'b0;
                end
            end
            checks++;
            if (!got || bad) begin
                errors++;
                $display("FAIL sweep_%0d: got done=%b bad=%b last=%h want done=1 bad=0", v, got, bad, bus.dr_data);
            end
            tick();
        end
    endtask

    initial begin
        bus.req0  = 1'b0;
        bus.req1  = 1'b0;
        bus.data0 = 4'h0;
        bus.data1 = 4'h0;
        test_reset();
        test_single();
        test_contention();
        test_data_timeout();
        test_spacer_timeout();
        test_reset_mid();
        test_encoding_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
